// File: rtl/debounce_pulse.sv
// Push-button front end: two-flop synchronizer, debounce FSM and auto-repeat.
// Emits one-cycle enable pulses per accepted press and per repeat interval.
module debounce_pulse #(
  parameter int unsigned DEBOUNCE      = 16,
  parameter int unsigned REPEAT_DELAY  = 64,
  parameter int unsigned REPEAT_PERIOD = 16,
  parameter int unsigned CNT_W         = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  input  logic repeat_en,
  output logic enable,
  output logic pressed
);

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] RPT_LAST   = CNT_W'(REPEAT_DELAY - 1);
  // Modular reload: still yields REPEAT_PERIOD spacing when PERIOD exceeds DELAY.
  localparam logic [CNT_W-1:0] RPT_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REL_WAIT
  } state_e;

  state_e           state_q, state_d;
  logic             s1_q, s2_q;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic             enable_q, enable_d;
  logic             pressed_q, pressed_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      state_q   <= IDLE;
      dcnt_q    <= '0;
      rcnt_q    <= '0;
      enable_q  <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      s1_q      <= button;
      s2_q      <= s1_q;
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      rcnt_q    <= rcnt_d;
      enable_q  <= enable_d;
      pressed_q <= pressed_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    rcnt_d    = rcnt_q;
    enable_d  = 1'b0;
    pressed_d = pressed_q;
    case (state_q)
      IDLE: begin
        pressed_d = 1'b0;
        dcnt_d    = '0;
        if (s2_q) begin
          state_d = PRESS_WAIT;
          dcnt_d  = ONE;
        end
      end
      PRESS_WAIT: begin
        pressed_d = 1'b0;
        if (!s2_q) begin
          state_d = IDLE;
          dcnt_d  = '0;
        end else if (dcnt_q == DB_LAST) begin
          state_d   = HELD;
          enable_d  = 1'b1;
          pressed_d = 1'b1;
          rcnt_d    = '0;
          dcnt_d    = '0;
        end else begin
          dcnt_d = dcnt_q + ONE;
        end
      end
      HELD: begin
        pressed_d = 1'b1;
        // A release sample takes priority over a due repeat pulse.
        if (!s2_q) begin
          state_d = REL_WAIT;
          dcnt_d  = ONE;
        end else if (!repeat_en) begin
          rcnt_d = '0;
        end else if (rcnt_q == RPT_LAST) begin
          enable_d = 1'b1;
          rcnt_d   = RPT_RELOAD;
        end else begin
          rcnt_d = rcnt_q + ONE;
        end
      end
      REL_WAIT: begin
        pressed_d = 1'b1;
        if (s2_q) begin
          state_d = HELD;
          rcnt_d  = '0;
          dcnt_d  = '0;
        end else if (dcnt_q == DB_LAST) begin
          state_d   = IDLE;
          pressed_d = 1'b0;
          dcnt_d    = '0;
        end else begin
          dcnt_d = dcnt_q + ONE;
        end
      end
      default: begin
        state_d   = IDLE;
        dcnt_d    = '0;
        rcnt_d    = '0;
        pressed_d = 1'b0;
      end
    endcase
  end

  assign enable  = enable_q;
  assign pressed = pressed_q;

endmodule

// File: tb/tb_debounce_pulse.sv
// Directed bench for debounce_pulse: press/release latency, bounce rejection,
// auto-repeat timing, release glitch, async reset and late repeat_en.
module tb_debounce_pulse;

  localparam int unsigned DB = 4;
  localparam int unsigned RD = 8;
  localparam int unsigned RP = 3;
  localparam int unsigned CW = 8;

  logic clock;
  logic reset;
  logic button;
  logic repeat_en;
  logic enable;
  logic pressed;

  int   cyc;
  int   n_cmp;
  int   n_bad;
  int   pulses[$];
  logic prev_en;
  int   b2b;
  int   low_seen;
  logic watch_pressed;

  debounce_pulse #(
    .DEBOUNCE     (DB),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP),
    .CNT_W        (CW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .button   (button),
    .repeat_en(repeat_en),
    .enable   (enable),
    .pressed  (pressed)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Pulse log (edge number of each enable pulse), back-to-back and pressed watch.
  always @(negedge clock) begin
    if (enable === 1'b1) pulses.push_back(cyc);
    if (enable === 1'b1 && prev_en === 1'b1) b2b++;
    prev_en = enable;
    if (watch_pressed && pressed !== 1'b1) low_seen++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  function automatic int pulse_at(input int i);
    return (i < pulses.size()) ? pulses[i] : -1;
  endfunction

  int base, p, e0, r0, r1;
  int exp_off[6] = '{0, 8, 11, 14, 17, 20};

  initial begin
    n_cmp = 0; n_bad = 0; b2b = 0; low_seen = 0;
    prev_en = 1'b0; watch_pressed = 1'b0;
    reset = 1'b1; button = 1'b0; repeat_en = 1'b0;
    tick(2);
    check_eq("rst_enable", 32'(enable), 0);
    check_eq("rst_pressed", 32'(pressed), 0);
    reset = 1'b0;
    tick(3);

    // Clean press, no repeat, then release
    pulses.delete();
    button = 1'b1; base = cyc;
    tick(5);
    check_eq("t1_pre", 32'({enable, pressed}), 0);
    tick(1);
    check_eq("t1_pulse", 32'({enable, pressed}), 3);
    tick(1);
    check_eq("t1_after", 32'({enable, pressed}), 1);
    check_eq("t1_pulse_edge", pulse_at(0), base + 6);
    tick(23);
    check_eq("t1_count", pulses.size(), 1);
    button = 1'b0;
    tick(5);
    check_eq("t1_rel_hold", 32'(pressed), 1);
    tick(1);
    check_eq("t1_rel", 32'(pressed), 0);
    tick(4);

    // Bouncy press
    pulses.delete();
    button = 1'b1; tick(1);
    button = 1'b0; tick(1);
    button = 1'b1; tick(1);
    button = 1'b0; tick(1);
    button = 1'b1; base = cyc;
    tick(5);
    check_eq("t2_no_early", pulses.size(), 0);
    tick(10);
    check_eq("t2_count", pulses.size(), 1);
    check_eq("t2_edge", pulse_at(0), base + 6);
    button = 1'b0;
    tick(10);
    check_eq("t2_released", 32'(pressed), 0);

    // Auto-repeat: P, P+8, P+11, P+14, P+17, P+20
    pulses.delete();
    repeat_en = 1'b1; button = 1'b1; base = cyc; p = base + 6;
    tick(26);
    button = 1'b0; repeat_en = 1'b0;
    tick(1);
    check_eq("t3_count", pulses.size(), 6);
    for (int i = 0; i < 6; i++) check_eq($sformatf("t3_pulse%0d", i), pulse_at(i), p + exp_off[i]);
    check_eq("t3_count4", pulses.size() % 16, 6);
    tick(10);

    // Two-cycle release glitch while held restarts repeat timer
    pulses.delete();
    repeat_en = 1'b1; button = 1'b1; base = cyc; p = base + 6;
    tick(6);
    watch_pressed = 1'b1;
    tick(4);
    button = 1'b0;
    tick(2);
    button = 1'b1;
    tick(11);
    repeat_en = 1'b0; button = 1'b0;
    tick(1);
    watch_pressed = 1'b0;
    check_eq("t4_pressed_low", low_seen, 0);
    check_eq("t4_count", pulses.size(), 2);
    check_eq("t4_repeat_edge", pulse_at(1), p + 17);
    tick(10);

    // Async reset mid PRESS_WAIT, then mid HELD while enable is high
    button = 1'b1;
    tick(4);
    #1 reset = 1'b1;
    #1 check_eq("t5_pw_rst", 32'({enable, pressed}), 0);
    tick(1);
    reset = 1'b0; r0 = cyc;
    tick(5);
    check_eq("t5_pre", 32'({enable, pressed}), 0);
    tick(1);
    check_eq("t5_pulse", 32'({enable, pressed}), 3);
    #1 reset = 1'b1;
    #1 check_eq("t5_held_rst", 32'({enable, pressed}), 0);
    tick(1);
    reset = 1'b0; r1 = cyc;
    pulses.delete();
    tick(7);
    check_eq("t5_count", pulses.size(), 1);
    check_eq("t5_edge", pulse_at(0), r1 + 6);
    button = 1'b0;
    tick(10);

    // repeat_en rises after 50 held cycles
    pulses.delete();
    repeat_en = 1'b0; button = 1'b1; base = cyc;
    tick(56);
    repeat_en = 1'b1; e0 = cyc;
    tick(8);
    check_eq("t6_none_before", pulses.size(), 1);
    tick(1);
    check_eq("t6_count", pulses.size(), 2);
    check_eq("t6_edge", pulse_at(1), e0 + 8);
    button = 1'b0; repeat_en = 1'b0;
    tick(10);

    check_eq("back_to_back", b2b, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/debounce_pulse.md
# debounce_pulse

Front-end stage for the `count4` counter. It takes a raw, asynchronous push-button level and synchronizes and debounces it. It then emits single-cycle `enable` pulses: one per clean press, plus optional auto-repeat pulses while the button is held. Its `enable` output connects directly to the counter's `enable` input, and both blocks share `clock` and `reset`.

## Interface
- `DEBOUNCE`, default 16: consecutive identical synchronized samples required to accept a press or a release.
- `REPEAT_DELAY`, default 64: cycles in HELD before the first auto-repeat pulse.
- `REPEAT_PERIOD`, default 16: cycles between subsequent auto-repeat pulses.
- `CNT_W`, default 16: width of the internal debounce and repeat counters. All three timing parameters are ≥2 and <2^CNT_W.

Ports:
- `clock`  input  1  single clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `button`  input  1  raw button level, asynchronous to `clock`; may bounce.
- `repeat_en`  input  1  synchronous; 1 enables auto-repeat while held.
- `enable`  output  1  registered one-cycle pulse per accepted press or repeat; drives `count4.enable`.
- `pressed`  output  1  registered debounced button level.

## Operation
- Synchronizer: two flops, `button` → `s1` → `s2`. The FSM samples only `s2`.
- Debounce counter `dcnt` (`CNT_W` bits) and repeat counter `rcnt` (`CNT_W` bits).
- FSM states and transitions:
  - IDLE: `pressed`=0, `dcnt`=0.
    - `s2`=1 → PRESS_WAIT, with `dcnt` set to 1.
  - PRESS_WAIT: `pressed`=0.
    - `s2`=0 → IDLE, no pulse.
    - `s2`=1 and `dcnt`=DEBOUNCE-1 → HELD. On the same edge `enable` is set, `pressed` is set, and `rcnt` is cleared.
    - Otherwise `dcnt`++.
  - HELD: `pressed`=1.
    - `s2`=0 → REL_WAIT, with `dcnt` set to 1.
    - If `repeat_en`=1, `rcnt`++ each cycle.
    - When `rcnt` reaches REPEAT_DELAY-1, a repeat pulse fires. After that a pulse fires each time `rcnt` reaches REPEAT_DELAY+k·REPEAT_PERIOD-1; implement this by reloading `rcnt` to REPEAT_DELAY-REPEAT_PERIOD after each pulse, or an equivalent scheme.
    - If `repeat_en`=0, `rcnt` holds at 0. When `repeat_en` later rises, counting restarts from 0.
  - REL_WAIT: `pressed` stays 1.
    - `s2`=1 → HELD, with `rcnt` cleared and no pulse.
    - `s2`=0 and `dcnt`=DEBOUNCE-1 → IDLE, and `pressed` clears on that edge.
    - Otherwise `dcnt`++.
- `enable` is 1 for exactly one cycle per event. It defaults to 0 on every edge where it is not explicitly set.
- `enable` is never high in two consecutive cycles.
- Glitches shorter than DEBOUNCE samples never produce a pulse and never change `pressed`.

## Timing
- Reset (async assert): `s1`, `s2`, `enable`, `pressed`, `dcnt`, and `rcnt` go to 0, and the state goes to IDLE, immediately and without waiting for a clock edge.
- Reset mid-operation aborts any pending pulse. A button still held at reset release is treated as a new press and requires the full latency below.
- Press latency: let edge 1 be the first edge at which `s1` captures 1. `enable` and `pressed` rise after edge DEBOUNCE+2, and `enable` falls after edge DEBOUNCE+3, provided `button` stays 1 throughout.
- Release latency: `pressed` falls DEBOUNCE+2 edges after `s1` first captures 0, with the same counting rule.
- First repeat pulse: asserted REPEAT_DELAY edges after the press pulse edge. Subsequent repeat pulses follow every REPEAT_PERIOD edges while held with `repeat_en`=1.
- The downstream counter therefore increments exactly once per `enable` pulse.

## Test plan
- Reset, then a clean press held for 30 cycles with DEBOUNCE=4 and `repeat_en`=0 → one `enable` pulse after edge 6, and `pressed`=1 from edge 6. After release, `pressed`=0 six edges after `s1` first captures 0.
- Bouncy press: `button` toggles 1,0,1,0 on single cycles, then holds 1, with DEBOUNCE=4 → exactly one pulse, occurring 6 edges after the final rising sample. No pulse is generated during the bounces.
- Auto-repeat: DEBOUNCE=4, REPEAT_DELAY=8, REPEAT_PERIOD=3, `repeat_en`=1, held for 20 cycles after the press pulse → pulses at press edge P, then P+8, P+11, P+14, P+17, P+20. A downstream `count4` reads 6.
- Release glitch: while HELD, `button`=0 for 2 cycles with DEBOUNCE=4 → `pressed` stays 1, no extra pulse, and the repeat timer restarts.
- Async reset asserted mid PRESS_WAIT (and separately mid HELD) → `enable`=0 and `pressed`=0 immediately. With the button still held, one pulse occurs DEBOUNCE+2 edges after reset release.
- `repeat_en` toggled 0→1 after 50 held cycles with REPEAT_DELAY=8 → first repeat pulse exactly 8 edges after the `repeat_en` rise, and none before.
